// File: rtl/execute_cycle.sv
// MIPS EX stage: operand forwarding, ALU, dest-reg select, branch target into EX/MEM; 1-cycle latency.
// No backpressure: EX/MEM loads every cycle outside reset; FlushM loads a bubble.
module execute_cycle #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              FlushM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              BranchM,
    output logic              ZeroM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic [DATA_W-1:0] PCBranchM
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_branch;
    logic [REG_AW-1:0] write_reg;
    logic              zero;

    // ALUOutM is the registered value of the instruction now in MEM
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUOutM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALUOutM;
            default: write_data = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? SignImmE : write_data;

    always_comb begin
        case (ALUControlE)
            3'b010:  alu_result = src_a + src_b;
            3'b110:  alu_result = src_a - src_b;
            3'b000:  alu_result = src_a & src_b;
            3'b001:  alu_result = src_a | src_b;
            3'b111:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign write_reg = RegDstE ? RdE : RtE;
    assign pc_branch = PCPlus4E + (SignImmE << 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            BranchM    <= 1'b0;
            ZeroM      <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
            PCBranchM  <= '0;
        end else begin
            // a flushed slot keeps its data but can never commit or branch
            RegWriteM  <= RegWriteE & ~FlushM;
            MemtoRegM  <= MemtoRegE & ~FlushM;
            MemWriteM  <= MemWriteE & ~FlushM;
            BranchM    <= BranchE   & ~FlushM;
            ZeroM      <= zero      & ~FlushM;
            ALUOutM    <= alu_result;
            WriteDataM <= write_data;
            WriteRegM  <= write_reg;
            PCBranchM  <= pc_branch;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases then random traffic against a reference model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E, ResultW;
    logic [4:0]  RtE, RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FlushM;
    logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
    logic [31:0] ALUOutM, WriteDataM, PCBranchM;
    logic [4:0]  WriteRegM;

    int n_chk  = 0;
    int n_fail = 0;

    // reference EX/MEM contents
    logic        m_rw, m_m2r, m_mw, m_br, m_zero;
    logic [31:0] m_alu, m_wd, m_pcb;
    logic [4:0]  m_wr;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
        .RtE(RtE), .RdE(RdE), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .FlushM(FlushM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .BranchM(BranchM),
        .ZeroM(ZeroM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .PCBranchM(PCBranchM)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd, input logic [31:0] res_w, input logic [31:0] alu_m);
        if (sel == 2'd1) return res_w;
        if (sel == 2'd2) return alu_m;
        return rd;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd2: return a + b;
            3'd6: return a - b;
            3'd0: return a & b;
            3'd1: return a | b;
            3'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // model of one clock edge, using the inputs currently applied
    task automatic model_edge();
        logic [31:0] a, wd, b, r;
        if (!rst) begin
            {m_rw, m_m2r, m_mw, m_br, m_zero} = '0;
            m_alu = 0; m_wd = 0; m_pcb = 0; m_wr = 0;
        end else begin
            a  = pick(ForwardAE, RD1E, ResultW, m_alu);
            wd = pick(ForwardBE, RD2E, ResultW, m_alu);
            b  = ALUSrcE ? SignImmE : wd;
            r  = alu_ref(ALUControlE, a, b);
            m_rw   = RegWriteE && !FlushM;
            m_m2r  = MemtoRegE && !FlushM;
            m_mw   = MemWriteE && !FlushM;
            m_br   = BranchE && !FlushM;
            m_zero = (r == 0) && !FlushM;
            m_alu  = r;
            m_wd   = wd;
            m_wr   = RegDstE ? RdE : RtE;
            m_pcb  = PCPlus4E + SignImmE * 4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".RegWriteM"},  RegWriteM,  m_rw);
        chk({tag, ".MemtoRegM"},  MemtoRegM,  m_m2r);
        chk({tag, ".MemWriteM"},  MemWriteM,  m_mw);
        chk({tag, ".BranchM"},    BranchM,    m_br);
        chk({tag, ".ZeroM"},      ZeroM,      m_zero);
        chk({tag, ".ALUOutM"},    ALUOutM,    m_alu);
        chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
        chk({tag, ".WriteRegM"},  WriteRegM,  m_wr);
        chk({tag, ".PCBranchM"},  PCBranchM,  m_pcb);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        rst = 1'b1;
        {RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE} = '0;
        ALUControlE = 3'b010;
        RD1E = 0; RD2E = 0; SignImmE = 0; PCPlus4E = 0; ResultW = 0;
        RtE = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; FlushM = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        RD1E = 32'h55; RD2E = 32'h66; RegWriteE = 1'b1; MemWriteE = 1'b1;
        step("reset0");
        chk("reset0.ALUOutM_zero", ALUOutM, 32'd0);
        chk("reset0.RegWriteM_zero", RegWriteM, 32'd0);

        // add R-type
        idle_inputs();
        RD1E = 5; RD2E = 7; ALUControlE = 3'b010; RegDstE = 1'b1; RdE = 5'd3; RtE = 5'd9; RegWriteE = 1'b1;
        step("add");
        chk("add.ALUOutM_is12", ALUOutM, 32'd12);
        chk("add.WriteRegM_is3", WriteRegM, 32'd3);
        chk("add.ZeroM_is0", ZeroM, 32'd0);

        // beq target with negative offset
        idle_inputs();
        RD1E = 9; RD2E = 9; ALUControlE = 3'b110; BranchE = 1'b1; PCPlus4E = 32'h100; SignImmE = 32'hFFFF_FFFF;
        step("beq");
        chk("beq.ZeroM_is1", ZeroM, 32'd1);
        chk("beq.PCBranchM", PCBranchM, 32'h0000_00FC);

        // forwarding from own ALUOutM and from ResultW
        idle_inputs();
        RD1E = 10; RD2E = 10;
        step("fwd_prep");
        chk("fwd_prep.ALUOutM_is20", ALUOutM, 32'd20);
        RD1E = 32'h1111; RD2E = 32'h2222; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 4;
        step("fwd");
        chk("fwd.ALUOutM_is24", ALUOutM, 32'd24);
        chk("fwd.WriteDataM_is4", WriteDataM, 32'd4);

        // signed slt both ways
        idle_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'b111;
        step("slt_neg");
        chk("slt_neg.is1", ALUOutM, 32'd1);
        RD1E = 1; RD2E = 32'hFFFF_FFFF;
        step("slt_pos");
        chk("slt_pos.is0", ALUOutM, 32'd0);

        // store path, then flushed store
        idle_inputs();
        ALUSrcE = 1'b1; SignImmE = 8; RD1E = 32'h40; RD2E = 32'hAB; MemWriteE = 1'b1;
        step("sw");
        chk("sw.ALUOutM", ALUOutM, 32'h48);
        chk("sw.MemWriteM_is1", MemWriteM, 32'd1);
        FlushM = 1'b1;
        step("sw_flush");
        chk("sw_flush.MemWriteM_is0", MemWriteM, 32'd0);
        chk("sw_flush.WriteDataM", WriteDataM, 32'hAB);

        // mid-stream reset with live inputs, then release
        rst = 1'b0; FlushM = 1'b0;
        step("rst_mid");
        chk("rst_mid.WriteDataM_zero", WriteDataM, 32'd0);
        rst = 1'b1;
        step("rst_release");
        chk("rst_release.ALUOutM", ALUOutM, 32'h48);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 19) != 0);
            FlushM      = ($urandom_range(0, 3) == 0);
            {RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE} = 6'($urandom);
            ALUControlE = 3'($urandom);
            ForwardAE   = 2'($urandom);
            ForwardBE   = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                RD1E = $urandom_range(0, 3); RD2E = $urandom_range(0, 3);
                SignImmE = $urandom_range(0, 3); ResultW = $urandom_range(0, 3);
            end else begin
                RD1E = $urandom; RD2E = $urandom; SignImmE = $urandom; ResultW = $urandom;
            end
            PCPlus4E = $urandom;
            RtE = 5'($urandom);
            RdE = 5'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
